// File: rtl/ov7670_cfg_pkg.sv
// ov7670_cfg_pkg: shared ROM markers, FSM states and delay-counter sizing
package ov7670_cfg_pkg;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        DELAY,
        DONE
    } cfg_state_t;

    // $clog2(n) bits hold n-1; clamp to one bit so DELAY_CYCLES=1 still builds
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_delay_counter.sv
// cfg_delay_counter: loadable down-counter that flags when it sits at zero
// Ports: clk, rst (sync, active-high), load/load_val (preset), dec (count down), zero (count==0)
module cfg_delay_counter #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (load)
            r_cnt <= load_val;
        else if (dec && r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks an external config ROM and issues SCCB register writes
// Ports: clk, rst (sync, active-high), start (pulse), rom_addr/rom_data (1-cycle registered ROM),
//        cmd_valid/cmd_ready/cmd_reg/cmd_val (write offer to SCCB master), busy, done
module ov7670_config_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int         DELAY_CYCLES = 250000,
    parameter logic [7:0] LAST_ADDR    = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_val,
    output logic        busy,
    output logic        done
);

    localparam int CW = cnt_width(DELAY_CYCLES);

    cfg_state_t r_state, w_state_n;
    logic [7:0] r_addr, w_addr_n;
    logic [7:0] r_reg, w_reg_n;
    logic [7:0] r_val, w_val_n;
    logic       r_valid, w_valid_n;
    logic       w_load, w_dec, w_adv, w_zero, w_last;

    cfg_delay_counter #(.W(CW)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (CW'(DELAY_CYCLES - 1)),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_reg   <= '0;
            r_val   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_addr  <= w_addr_n;
            r_reg   <= w_reg_n;
            r_val   <= w_val_n;
            r_valid <= w_valid_n;
        end
    end

    assign w_last = (r_addr == LAST_ADDR);

    always_comb begin
        w_state_n = r_state;
        w_addr_n  = r_addr;
        w_reg_n   = r_reg;
        w_val_n   = r_val;
        w_valid_n = r_valid;
        w_load    = 1'b0;
        w_dec     = 1'b0;
        w_adv     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_addr_n  = '0;
                    w_state_n = FETCH;
                end
            end
            FETCH: w_state_n = DECODE;
            DECODE: begin
                if (rom_data == CFG_END) begin
                    w_state_n = DONE;
                end else if (rom_data == CFG_DELAY) begin
                    w_load    = 1'b1;
                    w_state_n = DELAY;
                end else begin
                    w_reg_n   = rom_data[15:8];
                    w_val_n   = rom_data[7:0];
                    w_valid_n = 1'b1;
                    w_state_n = SEND;
                end
            end
            SEND: begin
                // cmd_valid is always high here, so cmd_ready alone completes the handshake
                if (cmd_ready) begin
                    w_valid_n = 1'b0;
                    w_adv     = 1'b1;
                end
            end
            DELAY: begin
                w_adv = w_zero;
                w_dec = !w_zero;
            end
            default: w_state_n = IDLE;
        endcase
        if (w_adv) begin
            w_state_n = w_last ? DONE : FETCH;
            w_addr_n  = w_last ? r_addr : r_addr + 8'd1;
        end
    end

    assign rom_addr  = r_addr;
    assign cmd_valid = r_valid;
    assign cmd_reg   = r_reg;
    assign cmd_val   = r_val;
    assign busy      = !(r_state inside {IDLE, DONE});
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb_ov7670_config_sequencer: randomized self-checking bench with a ROM-walk reference model
module tb_ov7670_config_sequencer;

    localparam int D0 = 4;
    localparam int D1 = 3;

    logic        clk = 1'b0;
    logic        rst, start, start1, cmd_ready, cmd_ready1;
    logic [7:0]  rom_addr, rom_addr1, cmd_reg, cmd_val, cmd_reg1, cmd_val1;
    logic [15:0] rom_data, rom_data1;
    logic        cmd_valid, cmd_valid1, busy, busy1, done, done1;

    logic [15:0] rom0 [256];
    logic [15:0] rom1 [256];
    logic [15:0] hs_q[$], hs1_q[$], exp_q[$], ref_q[$];
    int          hs_cyc[$];
    int          cyc, unstable, vcycles, n_tests, n_fail;
    logic        p_valid, p_hs, p_rst;
    logic [15:0] p_cmd;

    always #5 clk = ~clk;

    ov7670_config_sequencer #(.DELAY_CYCLES(D0), .LAST_ADDR(8'd255)) u_dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reg(cmd_reg), .cmd_val(cmd_val),
        .busy(busy), .done(done)
    );

    ov7670_config_sequencer #(.DELAY_CYCLES(D1), .LAST_ADDR(8'd3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_reg(cmd_reg1), .cmd_val(cmd_val1),
        .busy(busy1), .done(done1)
    );

    always @(posedge clk) begin
        rom_data  <= rom0[rom_addr];
        rom_data1 <= rom1[rom_addr1];
        cyc       <= cyc + 1;
    end

    // handshake capture and hold-stability watch, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            hs_q.push_back({cmd_reg, cmd_val});
            hs_cyc.push_back(cyc);
        end
        if (cmd_valid) vcycles = vcycles + 1;
        if (p_valid === 1'b1 && !p_hs && !p_rst && {cmd_valid, cmd_reg, cmd_val} !== {1'b1, p_cmd})
            unstable = unstable + 1;
        p_valid = cmd_valid;
        p_hs    = !rst && cmd_valid && cmd_ready;
        p_rst   = rst;
        p_cmd   = {cmd_reg, cmd_val};
        if (!rst && cmd_valid1 && cmd_ready1) hs1_q.push_back({cmd_reg1, cmd_val1});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_cmd();
        logic [15:0] w;
        do w = 16'($urandom); while (w == 16'hFFFF || w == 16'hFFF0);
        return w;
    endfunction

    // walks the ROM as the rules describe: end marker stops, delay marker costs 2+d, commands cost 3
    function automatic int model(input logic [15:0] r [256], input int last, input int d);
        int c;
        c = 0;
        exp_q.delete();
        for (int a = 0; a <= last; a++) begin
            if (r[a] == 16'hFFFF) return c + 2;
            if (r[a] == 16'hFFF0) c += 2 + d;
            else begin
                exp_q.push_back(r[a]);
                c += 3;
            end
        end
        return c;
    endfunction

    task automatic fill_end();
        for (int a = 0; a < 256; a++) rom0[a] = 16'hFFFF;
    endtask

    task automatic run_pass(input bit rnd, output int cycles, output bit to);
        hs_q.delete();
        hs_cyc.delete();
        vcycles   = 0;
        unstable  = 0;
        cycles    = 0;
        to        = 1'b1;
        cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                cycles = i;
                to     = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) cmd_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        tick();
        @(negedge clk);
        n_tests++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr: got %0h want 0", rom_addr); end
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
        n_tests++; if (cmd_reg !== 8'h00) begin n_fail++; $display("FAIL reset_cmd_reg: got %0h want 0", cmd_reg); end
        n_tests++; if (cmd_val !== 8'h00) begin n_fail++; $display("FAIL reset_cmd_val: got %0h want 0", cmd_val); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_over_start: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if ({busy1, done1, rom_addr1} !== 10'h000) begin n_fail++; $display("FAIL reset_dut3: got %0h want 0", {busy1, done1, rom_addr1}); end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b want 0", busy); end
    endtask

    task automatic test_directed();
        int c, e;
        bit to;
        fill_end();
        rom0[0] = 16'h1280;
        rom0[1] = 16'hFFF0;
        rom0[2] = 16'h1214;
        e = model(rom0, 255, D0);
        run_pass(1'b0, c, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL dir_timeout: done never rose"); end
        n_tests++; if (c != e) begin n_fail++; $display("FAIL dir_cycles: got %0d want %0d", c, e); end
        n_tests++; if (hs_q.size() != 2) begin n_fail++; $display("FAIL dir_hs_count: got %0d want 2", hs_q.size()); end
        n_tests++; if (hs_q[0] !== 16'h1280) begin n_fail++; $display("FAIL dir_cmd0: got %h want 1280", hs_q[0]); end
        n_tests++; if (hs_q[1] !== 16'h1214) begin n_fail++; $display("FAIL dir_cmd1: got %h want 1214", hs_q[1]); end
        n_tests++; if (hs_cyc[1] - hs_cyc[0] != 2 + D0 + 3) begin n_fail++; $display("FAIL dir_delay_gap: got %0d want %0d", hs_cyc[1] - hs_cyc[0], 2 + D0 + 3); end
        n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL dir_stable: got %0d want 0", unstable); end
    endtask

    task automatic test_backpressure();
        fill_end();
        rom0[0]   = 16'h1180;
        cmd_ready = 1'b0;
        hs_q.delete();
        unstable = 0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && !cmd_valid; i++) tick();
        n_tests++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_rise: got %b want 1", cmd_valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++; if ({cmd_valid, cmd_reg, cmd_val} !== 17'h11180) begin n_fail++; $display("FAIL bp_hold_%0d: got %h want 11180", i, {cmd_valid, cmd_reg, cmd_val}); end
            @(posedge clk);
            #1;
        end
        n_tests++; if (hs_q.size() != 0) begin n_fail++; $display("FAIL bp_no_hs_while_low: got %0d want 0", hs_q.size()); end
        cmd_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) tick();
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", done); end
        n_tests++; if (hs_q.size() != 1) begin n_fail++; $display("FAIL bp_hs_count: got %0d want 1", hs_q.size()); end
        n_tests++; if (hs_q[0] !== 16'h1180) begin n_fail++; $display("FAIL bp_cmd: got %h want 1180", hs_q[0]); end
        n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d want 0", unstable); end
    endtask

    task automatic test_reset_in_delay();
        int c, e;
        bit to;
        fill_end();
        rom0[0]   = 16'hFFF0;
        rom0[1]   = 16'h1234;
        cmd_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rid_busy_in_delay: got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if ({rom_addr, busy, cmd_valid, done} !== 11'h000) begin n_fail++; $display("FAIL rid_idle: got %h want 0", {rom_addr, busy, cmd_valid, done}); end
        e = model(rom0, 255, D0);
        run_pass(1'b0, c, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rid_timeout: done never rose"); end
        n_tests++; if (c != e) begin n_fail++; $display("FAIL rid_cycles: got %0d want %0d", c, e); end
        n_tests++; if (hs_q.size() != 1 || hs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rid_replay: got %0d cmds first %h want 1 cmd %h", hs_q.size(), hs_q[0], exp_q[0]); end
    endtask

    task automatic test_end_at_zero();
        int c;
        bit to;
        fill_end();
        run_pass(1'b0, c, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL eaz_timeout: done never rose"); end
        n_tests++; if (c != 2) begin n_fail++; $display("FAIL eaz_cycles: got %0d want 2", c); end
        n_tests++; if (vcycles != 0) begin n_fail++; $display("FAIL eaz_valid_cycles: got %0d want 0", vcycles); end
        n_tests++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL eaz_addr: got %0h want 0", rom_addr); end
    endtask

    task automatic test_last_addr();
        int e, n;
        for (int a = 0; a < 256; a++) rom1[a] = rnd_cmd();
        e = model(rom1, 3, D1);
        hs1_q.delete();
        n      = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 200 && !done1; i++) begin
            tick();
            n++;
        end
        n_tests++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL la_done: got %b want 1", done1); end
        n_tests++; if (n != e) begin n_fail++; $display("FAIL la_cycles: got %0d want %0d", n, e); end
        n_tests++; if (hs1_q.size() != exp_q.size()) begin n_fail++; $display("FAIL la_count: got %0d want %0d", hs1_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_tests++; if (hs1_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL la_cmd%0d: got %h want %h", i, hs1_q[i], exp_q[i]); end
        end
        n_tests++; if (rom_addr1 !== 8'd3) begin n_fail++; $display("FAIL la_addr: got %0d want 3", rom_addr1); end
        repeat (5) tick();
        n_tests++; if ({done1, rom_addr1} !== 9'h103) begin n_fail++; $display("FAIL la_hold: got %h want 103", {done1, rom_addr1}); end
    endtask

    task automatic test_start_ignored();
        int c;
        bit to, pulsed;
        fill_end();
        for (int a = 0; a < 6; a++) rom0[a] = rnd_cmd();
        void'(model(rom0, 255, D0));
        hs_q.delete();
        unstable = 0;
        pulsed   = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            start = 1'b0;
            if (!pulsed && cmd_valid) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            cmd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        n_tests++; if ({done, pulsed} !== 2'b11) begin n_fail++; $display("FAIL si_done_pulsed: got %b want 11", {done, pulsed}); end
        n_tests++; if (hs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL si_count: got %0d want %0d", hs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_tests++; if (hs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL si_cmd%0d: got %h want %h", i, hs_q[i], exp_q[i]); end
        end
        ref_q = hs_q;
        run_pass(1'b1, c, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL si_replay_timeout: done never rose"); end
        n_tests++; if (hs_q.size() != ref_q.size()) begin n_fail++; $display("FAIL si_replay_count: got %0d want %0d", hs_q.size(), ref_q.size()); end
        foreach (ref_q[i]) begin
            n_tests++; if (hs_q[i] !== ref_q[i]) begin n_fail++; $display("FAIL si_replay%0d: got %h want %h", i, hs_q[i], ref_q[i]); end
        end
        n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL si_stable: got %0d want 0", unstable); end
    endtask

    task automatic test_random();
        int c, e, len;
        bit to, rnd;
        for (int it = 0; it < 10; it++) begin
            rnd = it[0];
            fill_end();
            len = $urandom_range(1, 12);
            for (int a = 0; a < len; a++) rom0[a] = ($urandom_range(0, 4) == 0) ? 16'hFFF0 : rnd_cmd();
            e = model(rom0, 255, D0);
            run_pass(rnd, c, to);
            n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout: done never rose", it); end
            if (!rnd) begin
                n_tests++; if (c != e) begin n_fail++; $display("FAIL rnd%0d_cycles: got %0d want %0d", it, c, e); end
            end
            n_tests++; if (hs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", it, hs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) begin
                n_tests++; if (hs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_cmd%0d: got %h want %h", it, i, hs_q[i], exp_q[i]); end
            end
            n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL rnd%0d_stable: got %0d want 0", it, unstable); end
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        unstable   = 0;
        vcycles    = 0;
        p_valid    = 1'b0;
        p_hs       = 1'b0;
        p_rst      = 1'b1;
        p_cmd      = '0;
        rst        = 1'b1;
        start      = 1'b0;
        start1     = 1'b0;
        cmd_ready  = 1'b0;
        cmd_ready1 = 1'b1;
        for (int a = 0; a < 256; a++) begin
            rom0[a] = 16'hFFFF;
            rom1[a] = 16'hFFFF;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_in_delay();
        test_end_at_zero();
        test_last_addr();
        test_start_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
